// File: rtl/da_fir_feeder.sv
// -----------------------------------------------------------------------------
// da_fir_feeder
//
// Feeds the distributed-arithmetic FIR core from a valid/ready sample stream.
// Samples are buffered in a small circular FIFO. Each sample is issued to the
// core with a single-cycle fir_start pulse. The block then follows the core's
// fir_ready level through its busy/done cycle, captures fir_yout and presents
// it on a valid/ready result stream. Only one sample is in the core at a time,
// so results leave in the same order the samples arrived.
//
// Parameters
//   OPSIZE     sample/result width; must match the FIR core operand size
//   DEPTH      FIFO entries; power of two, >= 2
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   s_valid    input sample valid
//   s_ready    FIFO not full (held low during reset)
//   s_data     input sample
//   fir_start  registered one-cycle start pulse to the core
//   fir_xin    sample to the core; held until the next start
//   fir_ready  core idle/done level (sampled as a level, never edge-detected)
//   fir_yout   core result, valid while fir_ready=1 after a run
//   m_valid    result valid
//   m_ready    downstream accepts the result
//   m_data     result
//   fir_err    sticky: the core failed to drop fir_ready after a start
// -----------------------------------------------------------------------------
module da_fir_feeder #(
   parameter int OPSIZE = 12,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [OPSIZE-1:0] s_data,
   output logic              fir_start,
   output logic [OPSIZE-1:0] fir_xin,
   input  logic              fir_ready,
   input  logic [OPSIZE-1:0] fir_yout,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [OPSIZE-1:0] m_data,
   output logic              fir_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_LOW,
      S_WAIT_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic              s_ready_q, s_ready_d;
   logic              fir_start_q, fir_start_d;
   logic [OPSIZE-1:0] fir_xin_q, fir_xin_d;
   logic              m_valid_q, m_valid_d;
   logic [OPSIZE-1:0] m_data_q, m_data_d;
   logic              fir_err_q, fir_err_d;

   logic [OPSIZE-1:0] mem_q [DEPTH];

   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic              full_next;
   logic [AW-1:0]     wr_idx;
   logic [AW-1:0]     rd_idx;

   assign wr_idx     = wr_ptr_q[AW-1:0];
   assign rd_idx     = rd_ptr_q[AW-1:0];
   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign push       = s_valid && s_ready_q;

   // -------------------------------------------------------------------------
   // FIFO pointers. The extra MSB distinguishes full from empty. s_ready is
   // registered from the next-state pointers so it equals !full every cycle
   // after reset, and stays low while reset is asserted.
   // -------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
      full_next = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      s_ready_d = !full_next;
   end

   // -------------------------------------------------------------------------
   // Sequencer. The output register update is folded in here because a
   // capture in WAIT_DONE must win over the downstream clearing m_valid.
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default before the case, so no
      // path leaves a signal unassigned and no latch is inferred.
      state_d     = state_q;
      fir_start_d = 1'b0;
      fir_xin_d   = fir_xin_q;
      m_valid_d   = m_valid_q && !m_ready;
      m_data_d    = m_data_q;
      fir_err_d   = fir_err_q;
      pop         = 1'b0;

      case (state_q)
         S_IDLE: begin
            // The output-slot term keeps a capture from ever overwriting an
            // unconsumed result.
            if (!fifo_empty && fir_ready && (!m_valid_q || m_ready)) begin
               state_d     = S_START;
               fir_start_d = 1'b1;
               fir_xin_d   = mem_q[rd_idx];
               pop         = 1'b1;
            end
         end
         S_START: begin
            state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            if (fir_ready) begin
               // Core never went busy: the sample is dropped.
               fir_err_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (fir_ready) begin
               m_valid_d = 1'b1;
               m_data_d  = fir_yout;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         s_ready_q   <= 1'b0;
         fir_start_q <= 1'b0;
         fir_xin_q   <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         fir_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         s_ready_q   <= s_ready_d;
         fir_start_q <= fir_start_d;
         fir_xin_q   <= fir_xin_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         fir_err_q   <= fir_err_d;
      end
   end

   // NOTE: the FIFO storage has no reset; an entry is only read after it has
   // been written, and resetting the pointers is enough to empty the FIFO.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_idx] <= s_data;
      end
   end

   assign s_ready   = s_ready_q;
   assign fir_start = fir_start_q;
   assign fir_xin   = fir_xin_q;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign fir_err   = fir_err_q;

endmodule

// File: tb/tb_da_fir_feeder.sv
// -----------------------------------------------------------------------------
// Bench for da_fir_feeder. A behavioural FIR core drops fir_ready for 5 cycles
// after each accepted start and returns yout = xin ^ 0xFFF. Accepted samples
// are queued; on each fir_start the head is compared with fir_xin and the
// expected result is queued; each result handshake pops and compares.
// -----------------------------------------------------------------------------
module tb_da_fir_feeder;

   localparam int OPSIZE = 12;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              s_valid;
   logic              s_ready;
   logic [OPSIZE-1:0] s_data;
   logic              fir_start;
   logic [OPSIZE-1:0] fir_xin;
   logic              fir_ready;
   logic [OPSIZE-1:0] fir_yout;
   logic              m_valid;
   logic              m_ready;
   logic [OPSIZE-1:0] m_data;
   logic              fir_err;

   da_fir_feeder #(.OPSIZE(OPSIZE), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .fir_start (fir_start),
      .fir_xin   (fir_xin),
      .fir_ready (fir_ready),
      .fir_yout  (fir_yout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .fir_err   (fir_err)
   );

   always #5 clk = ~clk;

   // ---------------- core model ----------------
   logic              core_hold   = 1'b0;   // force fir_ready low
   logic              core_ignore = 1'b0;   // core ignores fir_start
   logic              core_rdy_q  = 1'b1;
   int                core_cnt    = 0;
   logic [OPSIZE-1:0] core_y      = '0;

   always @(posedge clk) begin
      if (fir_start && !core_ignore) begin
         core_rdy_q <= 1'b0;
         core_cnt   <= 5;
         core_y     <= fir_xin ^ 12'hFFF;
      end else if (core_cnt > 1) begin
         core_cnt <= core_cnt - 1;
      end else if (core_cnt == 1) begin
         core_cnt   <= 0;
         core_rdy_q <= 1'b1;
      end
   end

   assign fir_ready = core_hold ? 1'b0 : core_rdy_q;
   assign fir_yout  = core_y;

   // ---------------- bookkeeping ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   logic [OPSIZE-1:0] in_q[$];
   logic [OPSIZE-1:0] res_q[$];
   int   n_push   = 0;
   int   n_start  = 0;
   int   n_result = 0;
   int   cyc      = 0;
   int   start_cyc = 0;
   int   last_lat  = 0;
   bit   mon_en    = 1'b0;
   bit   prev_start = 1'b0;
   bit   prev_mv    = 1'b0;
   bit   saw_full   = 1'b0;
   bit   seen_mv    = 1'b0;

   always @(posedge clk) cyc++;

   // Monitor: sampled on the falling edge, inputs change 1 time unit after
   // the rising edge. A handshake seen here completes on the next rising edge.
   always @(negedge clk) begin
      logic [OPSIZE-1:0] x;
      if (mon_en) begin
         if (fir_start) begin
            check("fir_start_single_cycle", {31'd0, prev_start}, 32'd0);
            if (in_q.size() == 0) begin
               check("unexpected_start", {31'd0, fir_start}, 32'd0);
            end else begin
               x = in_q.pop_front();
               check("fir_xin", {20'd0, fir_xin}, {20'd0, x});
               if (!core_ignore) res_q.push_back(x ^ 12'hFFF);
            end
            n_start++;
            start_cyc = cyc;
         end
         check("s_ready_vs_occupancy", {31'd0, s_ready},
               {31'd0, ((n_push - n_start) < DEPTH)});
         if (!s_ready) saw_full = 1'b1;
         if (s_valid && s_ready) begin
            in_q.push_back(s_data);
            n_push++;
         end
         if (m_valid && !prev_mv) last_lat = cyc - start_cyc;
         if (m_valid) seen_mv = 1'b1;
         if (m_valid && m_ready) begin
            if (res_q.size() == 0) begin
               check("unexpected_result", {31'd0, m_valid}, 32'd0);
            end else begin
               x = res_q.pop_front();
               check("m_data", {20'd0, m_data}, {20'd0, x});
            end
            n_result++;
         end
         prev_start = fir_start;
         prev_mv    = m_valid;
      end else begin
         prev_start = 1'b0;
         prev_mv    = 1'b0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push(input logic [OPSIZE-1:0] d);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      while (!ok && n < 100) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk);
         #1;
         n++;
      end
      s_valid = 1'b0;
      check("push_accepted", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_start();
      int n;
      n = 0;
      @(negedge clk);
      while (!fir_start && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("start_seen", {31'd0, fir_start}, 32'd1);
   endtask

   task automatic wait_mvalid();
      int n;
      n = 0;
      @(negedge clk);
      while (!m_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("m_valid_seen", {31'd0, m_valid}, 32'd1);
   endtask

   task automatic wait_drain();
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 400) begin
         @(negedge clk);
         done = (in_q.size() == 0) && (res_q.size() == 0) && !m_valid && !fir_start;
         n++;
      end
      check("drained", {31'd0, done}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_s_ready"},   {31'd0, s_ready},   32'd0);
      check({tag, "_fir_start"}, {31'd0, fir_start}, 32'd0);
      check({tag, "_fir_xin"},   {20'd0, fir_xin},   32'd0);
      check({tag, "_m_valid"},   {31'd0, m_valid},   32'd0);
      check({tag, "_m_data"},    {20'd0, m_data},    32'd0);
      check({tag, "_fir_err"},   {31'd0, fir_err},   32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int r0;
      int s0;

      rst     = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      m_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("s_ready_after_release", {31'd0, s_ready}, 32'd1);
      mon_en = 1'b1;

      // Single sample: 0x7FF -> 0x800, start-to-valid latency 7
      push(12'h7FF);
      wait_drain();
      check("start_to_valid_latency", last_lat, 32'd7);
      check("t1_fir_err", {31'd0, fir_err}, 32'd0);

      // Six back-to-back samples, FIFO must fill
      r0       = n_result;
      saw_full = 1'b0;
      for (int i = 1; i <= 6; i++) push(i[OPSIZE-1:0]);
      wait_drain();
      check("t2_fifo_filled", {31'd0, saw_full}, 32'd1);
      check("t2_result_count", n_result - r0, 32'd6);

      // Back-pressure on the result blocks the next issue
      m_ready = 1'b0;
      push(12'h100);
      push(12'h200);
      wait_mvalid();
      s0 = n_start;
      repeat (20) @(negedge clk);
      check("t3_no_issue_while_blocked", n_start, s0);
      check("t3_m_valid_held", {31'd0, m_valid}, 32'd1);
      check("t3_m_data_held", {20'd0, m_data}, 32'hEFF);
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      @(negedge clk);
      check("t3_start_not_yet", {31'd0, fir_start}, 32'd0);
      @(negedge clk);
      check("t3_start_next_cycle", {31'd0, fir_start}, 32'd1);
      wait_drain();

      // Core ignores the start: error two cycles later, sample dropped
      core_ignore = 1'b1;
      push(12'h055);
      wait_start();
      check("t4_err_at_start", {31'd0, fir_err}, 32'd0);
      @(negedge clk);
      check("t4_err_plus1", {31'd0, fir_err}, 32'd0);
      @(negedge clk);
      check("t4_err_plus2", {31'd0, fir_err}, 32'd1);
      core_ignore = 1'b0;
      @(posedge clk);
      #1;
      push(12'h0AA);
      wait_drain();
      check("t4_err_sticky", {31'd0, fir_err}, 32'd1);

      // Reset during WAIT_DONE with two samples still queued
      core_hold = 1'b1;
      push(12'h311);
      push(12'h322);
      push(12'h333);
      core_hold = 1'b0;
      wait_start();
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      in_q.delete();
      res_q.delete();
      n_push  = 0;
      n_start = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      seen_mv = 1'b0;
      mon_en  = 1'b1;
      repeat (20) @(negedge clk);
      check("t5_no_stale_valid", {31'd0, seen_mv}, 32'd0);
      check("t5_no_start_after_reset", n_start, 32'd0);
      check("t5_s_ready", {31'd0, s_ready}, 32'd1);
      @(posedge clk);
      #1;

      // fir_ready held low: FIFO fills, nothing issues
      core_hold = 1'b1;
      for (int i = 0; i < DEPTH; i++) push(12'h600 + i[OPSIZE-1:0]);
      @(negedge clk);
      check("t6_s_ready_full", {31'd0, s_ready}, 32'd0);
      check("t6_no_start", n_start, 32'd0);
      @(posedge clk);
      #1;
      core_hold = 1'b0;
      wait_drain();
      check("t6_all_issued", n_start, DEPTH);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
